// File: rtl/spi_master_px.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_master_px                                                              |
// | SPI master for the ILI9341 display path: one DATA_W-bit word per           |
// | transaction, MSB first, any CPOL/CPHA, programmable SCLK divider, CS hold   |
// | across bursts. Optional receive path enabled by SPI_MASTER_PX_RX_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_master_px #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_send,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_dc_in,
    input  logic              i_keep_cs,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_cs_n,
    output logic              o_dc
`ifdef SPI_MASTER_PX_RX_EN
    ,
    input  logic              i_miso,
    output logic [DATA_W-1:0] o_rx_data
`endif
);

    localparam int c_DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_EDGE_W = $clog2(2*DATA_W+1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LOAD  = c_DIV_W'(CLK_DIV-1);
    localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(2*DATA_W);
    localparam logic [c_EDGE_W-1:0] c_ONE       = c_EDGE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_DIV_W-1:0]   r_div;
    logic [c_EDGE_W-1:0]  r_edge;
    logic [DATA_W-1:0]    r_shift;
    logic                 r_keep;
    logic                 r_sclk;
    logic                 r_cs_n;
    logic                 r_dc;
    logic                 r_done;

    logic                 w_div_tc;
    logic [c_EDGE_W-1:0]  w_edge_num;
    logic                 w_leading;
    logic                 w_shift_en;
    logic [DATA_W-1:0]    w_shift_next;

    assign w_div_tc     = (r_div == '0);
    assign w_edge_num   = r_edge + c_ONE;
    assign w_leading    = w_edge_num[0];
    assign w_shift_next = DATA_W'({r_shift, 1'b0});

    // Shift on the non-sampling edges, skipping the one that would precede
    // the first sample (CPHA=1) or follow the last one (CPHA=0).
    always_comb begin
        w_shift_en = 1'b0;
        if (CPHA) begin
            w_shift_en = w_leading && (w_edge_num > c_ONE);
        end else begin
            w_shift_en = !w_leading && (w_edge_num < c_LAST_EDGE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_edge  <= '0;
            r_shift <= '0;
            r_keep  <= 1'b0;
            r_sclk  <= CPOL;
            r_cs_n  <= 1'b1;
            r_dc    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_send) begin
                        r_shift <= i_data_in;
                        r_dc    <= i_dc_in;
                        r_keep  <= i_keep_cs;
                        r_cs_n  <= 1'b0;
                        r_div   <= c_DIV_LOAD;
                        r_edge  <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_div_tc) begin
                        r_div   <= c_DIV_LOAD;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_div_tc) begin
                        r_div  <= c_DIV_LOAD;
                        r_sclk <= ~r_sclk;
                        r_edge <= w_edge_num;
                        if (w_shift_en) begin
                            r_shift <= w_shift_next;
                        end
                        if (w_edge_num == c_LAST_EDGE) begin
                            r_state <= S_HOLD;
                        end
                    end else begin
                        r_div <= r_div - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_div_tc) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_div <= r_div - 1'b1;
                    end
                end
                S_DONE: begin
                    r_cs_n  <= ~r_keep;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_MASTER_PX_RX_EN
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic              w_sample;

    assign w_sample = CPHA ? !w_leading : w_leading;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx      <= '0;
            r_rx_data <= '0;
        end else begin
            if ((r_state == S_SHIFT) && w_div_tc && w_sample) begin
                r_rx <= DATA_W'({r_rx, i_miso});
            end
            if ((r_state == S_HOLD) && w_div_tc) begin
                r_rx_data <= r_rx;
            end
        end
    end

    assign o_rx_data = r_rx_data;
`endif

    assign o_ready = (r_state == S_IDLE);
    assign o_done  = r_done;
    assign o_sclk  = r_sclk;
    assign o_mosi  = r_shift[DATA_W-1];
    assign o_cs_n  = r_cs_n;
    assign o_dc    = r_dc;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_px.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_master_px                                                           |
// | Directed self-checking bench for spi_master_px (modes 0 and 3, bursts,     |
// | busy sends, mid-word reset; RX loopback when SPI_MASTER_PX_RX_EN is set).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_spi_master_px;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] data;
    logic       dcin, keep, send0, send3;
    logic       rdy0, done0, sclk0, mosi0, cs0, dc0;
    logic       rdy3, done3, sclk3, mosi3, cs3, dc3;
    int         checks = 0;
    int         failures = 0;
    bit         sel;
    bit   [1:0] lk;
    logic       m_rdy, m_done, m_sclk, m_mosi, m_cs, m_dc;
`ifdef SPI_MASTER_PX_RX_EN
    logic [7:0] rx0, rx3, m_rx;
`endif

    spi_master_px #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .i_send(send0), .i_data_in(data), .i_dc_in(dcin),
        .i_keep_cs(keep), .o_ready(rdy0), .o_done(done0), .o_sclk(sclk0),
        .o_mosi(mosi0), .o_cs_n(cs0), .o_dc(dc0)
`ifdef SPI_MASTER_PX_RX_EN
        , .i_miso(mosi0), .o_rx_data(rx0)
`endif
    );

    spi_master_px #(.DATA_W(8), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
        .clk(clk), .rst(rst), .i_send(send3), .i_data_in(data), .i_dc_in(dcin),
        .i_keep_cs(keep), .o_ready(rdy3), .o_done(done3), .o_sclk(sclk3),
        .o_mosi(mosi3), .o_cs_n(cs3), .o_dc(dc3)
`ifdef SPI_MASTER_PX_RX_EN
        , .i_miso(mosi3), .o_rx_data(rx3)
`endif
    );

    always_comb begin
        m_rdy  = sel ? rdy3  : rdy0;
        m_done = sel ? done3 : done0;
        m_sclk = sel ? sclk3 : sclk0;
        m_mosi = sel ? mosi3 : mosi0;
        m_cs   = sel ? cs3   : cs0;
        m_dc   = sel ? dc3   : dc0;
`ifdef SPI_MASTER_PX_RX_EN
        m_rx   = sel ? rx3   : rx0;
`endif
    end

`ifdef SPI_MASTER_PX_RX_EN
    logic [3:0]  s16, rdy16, done16, sclk16, mosi16, cs16, dc16;
    logic [15:0] rx16 [4];
    for (genvar m = 0; m < 4; m++) begin : g_rx
        spi_master_px #(.DATA_W(16), .CLK_DIV(2), .CPOL(1'(m/2)), .CPHA(1'(m%2))) u_rx (
            .clk(clk), .rst(rst), .i_send(s16[m]), .i_data_in(16'hBEEF),
            .i_dc_in(1'b0), .i_keep_cs(1'b0), .o_ready(rdy16[m]), .o_done(done16[m]),
            .o_sclk(sclk16[m]), .o_mosi(mosi16[m]), .o_cs_n(cs16[m]), .o_dc(dc16[m]),
            .i_miso(mosi16[m]), .o_rx_data(rx16[m])
        );
    end
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic drive_send(input bit s, input logic v);
        if (s) send3 = v;
        else   send0 = v;
    endtask

    // Called at a falling clk edge; returns at the falling edge of the cycle after done.
    task automatic xfer(input bit s, input logic [7:0] d, input bit dv, input bit kv,
                        input int lat, input int busy_k, input bit send_in_done);
        logic [7:0] bits = '0;
        int   rises = 0;
        int   k;
        bit   seen = 0, dc_bad = 0, stab_bad = 0;
        logic prev_sclk, prev_mosi;
        sel = s;
        #1;
        check("idle_ready", m_rdy, 1);
        check("idle_sclk", m_sclk, s);
        check("idle_cs_n", m_cs, !lk[s]);
        data = d; dcin = dv; keep = kv;
        drive_send(s, 1'b1);
        prev_sclk = m_sclk;
        prev_mosi = m_mosi;
        @(posedge clk);
        @(negedge clk);
        drive_send(s, 1'b0);
        check("busy_ready", m_rdy, 0);
        for (k = 0; k <= lat + 4; k++) begin
            if (k > 0) @(negedge clk);
            if (k == busy_k) begin
                data = 8'hFF;
                drive_send(s, 1'b1);
            end else if (k == busy_k + 1) begin
                drive_send(s, 1'b0);
            end
            if (!m_cs && (m_dc !== dv)) dc_bad = 1;
            if (!prev_sclk && m_sclk) begin
                rises++;
                bits = {bits[6:0], m_mosi};
                if (m_mosi !== prev_mosi) stab_bad = 1;
            end
            prev_sclk = m_sclk;
            prev_mosi = m_mosi;
            if (m_done) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", seen, 1);
        check("latency", k, lat);
        check("mosi_bits", bits, d);
        check("sclk_rises", rises, 8);
        check("dc_stable", dc_bad, 0);
        check("mosi_stable", stab_bad, 0);
        check("end_sclk", m_sclk, s);
`ifdef SPI_MASTER_PX_RX_EN
        check("rx_data", m_rx, d);
`endif
        if (send_in_done) begin
            data = 8'hFF;
            drive_send(s, 1'b1);
        end
        @(negedge clk);
        drive_send(s, 1'b0);
        check("done_pulse", m_done, 0);
        check("ready_after", m_rdy, 1);
        check("cs_n_after", m_cs, !kv);
        check("dc_hold", m_dc, dv);
        lk[s] = kv;
    endtask

    initial begin
        int extra;
        rst = 1'b0; send0 = 0; send3 = 0; data = '0; dcin = 0; keep = 0;
        sel = 0; lk = '0;
`ifdef SPI_MASTER_PX_RX_EN
        s16 = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ready", m_rdy, 1);
        check("rst_done", m_done, 0);
        check("rst_sclk0", m_sclk, 0);
        check("rst_sclk3", sclk3, 1);
        check("rst_mosi", m_mosi, 0);
        check("rst_cs_n", m_cs, 1);
        check("rst_dc", m_dc, 0);
`ifdef SPI_MASTER_PX_RX_EN
        check("rst_rx", m_rx, 0);
`endif
        rst = 1'b1;
        @(negedge clk);

        xfer(0, 8'hA5, 1, 0, 36, -1, 0);
        @(negedge clk);
        xfer(1, 8'h3C, 0, 0, 18, -1, 0);
        @(negedge clk);

        // Burst: CS held after 0x2C; send during DONE of 0x12 is ignored and
        // 0x34 is accepted in the first idle cycle.
        xfer(0, 8'h2C, 0, 1, 36, -1, 0);
        xfer(0, 8'h12, 1, 0, 36, -1, 1);
        xfer(0, 8'h34, 1, 0, 36, -1, 0);
        @(negedge clk);

        xfer(0, 8'h00, 0, 0, 36, 12, 0);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (m_done) extra++;
        end
        check("no_extra_done", extra, 0);

        sel = 0; data = 8'hF0; dcin = 1; keep = 1; send0 = 1;
        @(posedge clk);
        @(negedge clk);
        send0 = 0;
        repeat (17) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_cs_n", m_cs, 1);
        check("abort_sclk", m_sclk, 0);
        check("abort_ready", m_rdy, 1);
        check("abort_done", m_done, 0);
        check("abort_dc", m_dc, 0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (m_done) extra++;
        end
        check("abort_no_done", extra, 0);
        rst = 1'b1;
        lk = '0;
        @(negedge clk);
        xfer(0, 8'h81, 0, 0, 36, -1, 0);

`ifdef SPI_MASTER_PX_RX_EN
        for (int m = 0; m < 4; m++) begin
            int k;
            @(negedge clk);
            s16[m] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            s16[m] = 1'b0;
            for (k = 0; k <= 80; k++) begin
                if (k > 0) @(negedge clk);
                if (done16[m]) break;
            end
            check("rx_latency", k, 68);
            check("rx_loopback", rx16[m], 16'hBEEF);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d expected=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
